// File: rtl/tank_sprite_reader_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared types and constants for the tank sprite reader: facing direction,
// sprite geometry, transparent colour key and bus widths.
// -----------------------------------------------------------------------------
package tank_pkg;

  // Facing direction; the value doubles as the direction-RAM select.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  // Screen coordinate (column 0..639 or row 0..479).
  typedef logic [9:0] coord_t;

  localparam int          SPR_W   = 32;
  localparam int          SPR_H   = 32;
  localparam logic [23:0] KEY_RGB = 24'hFF0000;
  localparam int          CNT_W   = 11;
  localparam int          ADDR_W  = 19;
  localparam int          RGB_W   = 24;

endpackage

// File: rtl/tank_sprite_reader_if.sv
// -----------------------------------------------------------------------------
// tank_sprite_reader_if
// Read port toward the four direction sprite RAMs.
//   read_address : address presented to every direction RAM
//   dir_sel      : selects which RAM's data_Out is muxed back
//   data_In      : muxed RAM output, one clock after read_address is sampled
// master = the sprite reader, slave = the RAM side.
// -----------------------------------------------------------------------------
interface tank_sprite_reader_if;
  import tank_pkg::*;

  logic [ADDR_W-1:0] read_address;
  dir_t              dir_sel;
  logic [RGB_W-1:0]  data_In;

  modport master (output read_address, output dir_sel, input data_In);
  modport slave  (input read_address, input dir_sel, output data_In);

endinterface

// File: rtl/tank_sprite_reader.sv
// -----------------------------------------------------------------------------
// tank_sprite_reader
// Turns the VGA scan position and the tank's frame-latched position/direction
// into a sprite RAM address and select, aligns the returned colour with a draw
// flag (KEY_RGB is transparent) and reports last frame's opaque pixel count.
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   frame_start       : one-cycle pulse at start of vertical blank
//   pix_valid, DrawX/Y: scan position, valid when pix_valid=1
//   tank_*_in         : live tank position / facing, latched on frame_start
//   ram               : RAM read port (read_address, dir_sel, data_In)
//   pixel_rgb/draw    : sprite colour and opaque flag, 3 cycles after pix_valid
//   pixel_out_valid   : pixel_rgb/pixel_draw belong to an accepted pixel
//   opaque_count      : opaque pixels drawn during the previous frame
// -----------------------------------------------------------------------------
module tank_sprite_reader
  import tank_pkg::*;
#(
  parameter int          SPR_W   = tank_pkg::SPR_W,
  parameter int          SPR_H   = tank_pkg::SPR_H,
  parameter logic [23:0] KEY_RGB = tank_pkg::KEY_RGB,
  parameter int          CNT_W   = tank_pkg::CNT_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  coord_t               DrawX,
  input  coord_t               DrawY,
  input  coord_t               tank_x_in,
  input  coord_t               tank_y_in,
  input  dir_t                 tank_dir_in,
  tank_sprite_reader_if.master ram,
  output logic [RGB_W-1:0]     pixel_rgb,
  output logic                 pixel_draw,
  output logic                 pixel_out_valid,
  output logic [CNT_W-1:0]     opaque_count
);

  localparam int AW = $clog2(SPR_W);
  localparam int AH = $clog2(SPR_H);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  coord_t             r_sx;
  coord_t             r_sy;
  dir_t               r_sdir;
  logic [ADDR_W-1:0]  r_read_address;
  logic               r_va;
  logic               r_boxa;
  logic               r_vb;
  logic               r_boxb;
  logic [RGB_W-1:0]   r_pixel_rgb;
  logic               r_pixel_draw;
  logic               r_pixel_out_valid;
  logic [CNT_W-1:0]   r_run_count;
  logic [CNT_W-1:0]   r_opaque_count;

  logic [AW-1:0]      w_dx;
  logic [AH-1:0]      w_dy;
  logic               w_in_box;

  // Only the low bits of the offsets form the address; the box test below
  // is done in 11 bits so a sprite near the right/bottom edge never wraps.
  assign w_dx = AW'(DrawX - r_sx);
  assign w_dy = AH'(DrawY - r_sy);
  assign w_in_box = ({1'b0, DrawX} >= {1'b0, r_sx}) &&
                    ({1'b0, DrawX} <  ({1'b0, r_sx} + 11'(SPR_W))) &&
                    ({1'b0, DrawY} >= {1'b0, r_sy}) &&
                    ({1'b0, DrawY} <  ({1'b0, r_sy} + 11'(SPR_H)));

  // Shadow copy of the tank state, refreshed only at frame start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sx   <= 10'd0;
      r_sy   <= 10'd0;
      r_sdir <= UP;
    end else if (frame_start) begin
      r_sx   <= tank_x_in;
      r_sy   <= tank_y_in;
      r_sdir <= tank_dir_in;
    end
  end

  // Stage A: address generation; the address holds between accepted pixels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_read_address <= '0;
      r_va           <= 1'b0;
      r_boxa         <= 1'b0;
    end else begin
      r_va   <= pix_valid;
      r_boxa <= pix_valid && w_in_box;
      if (pix_valid) begin
        r_read_address <= w_in_box ? ADDR_W'({w_dy, w_dx}) : '0;
      end
    end
  end

  // Stage B: delay valid/box to line up with the RAM's registered data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vb   <= 1'b0;
      r_boxb <= 1'b0;
    end else begin
      r_vb   <= r_va;
      r_boxb <= r_boxa;
    end
  end

  // Stage C: output registers with transparent-key suppression.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pixel_out_valid <= 1'b0;
      r_pixel_rgb       <= '0;
      r_pixel_draw      <= 1'b0;
    end else begin
      r_pixel_out_valid <= r_vb;
      r_pixel_rgb       <= r_boxb ? ram.data_In : '0;
      r_pixel_draw      <= r_vb && r_boxb && (ram.data_In != KEY_RGB);
    end
  end

  // Opaque pixel counter; a draw coincident with frame_start opens the new frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_run_count    <= '0;
      r_opaque_count <= '0;
    end else if (frame_start) begin
      r_opaque_count <= r_run_count;
      r_run_count    <= r_pixel_draw ? CNT_W'(1) : '0;
    end else if (r_pixel_draw && (r_run_count != CNT_MAX)) begin
      r_run_count <= r_run_count + CNT_W'(1);
    end
  end

  assign ram.read_address = r_read_address;
  assign ram.dir_sel      = r_sdir;
  assign pixel_rgb        = r_pixel_rgb;
  assign pixel_draw       = r_pixel_draw;
  assign pixel_out_valid  = r_pixel_out_valid;
  assign opaque_count     = r_opaque_count;

endmodule

// File: tb/tb_tank_sprite_reader.sv
// -----------------------------------------------------------------------------
// tb_tank_sprite_reader
// Drives tank_sprite_reader with a behavioural sprite RAM, a directed vector
// table, hand-written shadow/counter/reset sequences and random scans, all
// compared against a pixel-level reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_tank_sprite_reader;
  import tank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pix_valid;
  coord_t      DrawX, DrawY, tank_x_in, tank_y_in;
  dir_t        tank_dir_in;
  logic [23:0] pixel_rgb;
  logic        pixel_draw;
  logic        pixel_out_valid;
  logic [10:0] opaque_count;

  logic [23:0] mem [0:1023];

  tank_sprite_reader_if ram_bus ();

  tank_sprite_reader dut (
    .Clk            (clk),
    .Reset          (rst),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .tank_x_in      (tank_x_in),
    .tank_y_in      (tank_y_in),
    .tank_dir_in    (tank_dir_in),
    .ram            (ram_bus),
    .pixel_rgb      (pixel_rgb),
    .pixel_draw     (pixel_draw),
    .pixel_out_valid(pixel_out_valid),
    .opaque_count   (opaque_count)
  );

  always #5 clk = ~clk;

  // Behavioural sprite RAM: registered read of the bench's memory image.
  always @(posedge clk) ram_bus.data_In <= mem[ram_bus.read_address[9:0]];

  // ---------------- reference model ----------------
  typedef struct { bit v; bit d; logic [23:0] rgb; } prec_t;
  prec_t q[$];
  prec_t last;
  int    m_sx, m_sy, m_sdir, m_addr, m_run, m_opaque;
  bit    cur_draw;
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(pixel_out_valid), 32'(last.v));
    chk("draw", 32'(pixel_draw), 32'(last.d));
    chk("rgb", 32'(pixel_rgb), 32'(last.rgb));
    chk("addr", 32'(ram_bus.read_address), m_addr);
    chk("dir_sel", 32'(ram_bus.dir_sel), m_sdir);
    chk("opaque", 32'(opaque_count), m_opaque);
  endtask

  // Reset clears everything; the pipeline holds two empty slots afterwards.
  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_sx = 0; m_sy = 0; m_sdir = 0; m_addr = 0; m_run = 0; m_opaque = 0;
    cur_draw = 1'b0;
    q.delete();
    last = '{1'b0, 1'b0, 24'h0};
    q.push_back(last);
    q.push_back(last);
    check_all();
  endtask

  // One clock: model the presented pixel, clock the DUT, compare every output.
  task automatic cycle(input bit fs, input bit pv, input int x, input int y);
    bit    inb;
    int    a;
    prec_t r;
    frame_start = fs; pix_valid = pv; DrawX = 10'(x); DrawY = 10'(y);
    inb = pv && (x >= m_sx) && (x < m_sx + 32) && (y >= m_sy) && (y < m_sy + 32);
    a = inb ? (y - m_sy) * 32 + (x - m_sx) : 0;
    r.v = pv;
    r.rgb = inb ? mem[a] : 24'h0;
    r.d = inb && (mem[a] != KEY_RGB);
    if (pv) m_addr = a;
    if (fs) begin
      m_opaque = m_run;
      m_run = cur_draw ? 1 : 0;
      m_sx = int'(tank_x_in); m_sy = int'(tank_y_in); m_sdir = int'(tank_dir_in);
    end else if (cur_draw && m_run < 2047) begin
      m_run++;
    end
    q.push_back(r);
    @(posedge clk); #1;
    last = q.pop_front();
    cur_draw = last.d;
    check_all();
    frame_start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0);
  endtask

  task automatic set_tank(input int x, input int y, input int d);
    tank_x_in = 10'(x); tank_y_in = 10'(y); tank_dir_in = dir_t'(d);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct { int tx; int ty; int dir; int x; int y; int exp_addr; bit exp_in; } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{100, 200, 2, 100, 200,    0, 1'b1};
    tbl[1] = '{100, 200, 2, 101, 200,    1, 1'b1};
    tbl[2] = '{100, 200, 2, 131, 231, 1023, 1'b1};
    tbl[3] = '{100, 200, 2, 132, 200,    0, 1'b0};
    tbl[4] = '{100, 200, 2,  99, 200,    0, 1'b0};
    tbl[5] = '{620,   0, 1, 639,   5,  179, 1'b1};
    tbl[6] = '{620,   0, 1,   0,   5,    0, 1'b0};
    tbl[7] = '{600, 470, 3, 605, 479,  293, 1'b1};
    tbl[8] = '{  0,   0, 0,  31,   0,   31, 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = {4'h1, 10'(i), 10'(i)};
    mem[0] = KEY_RGB;
    mem[1] = 24'h142608;
    DrawX = 10'd0; DrawY = 10'd0;
    set_tank(0, 0, 0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      logic [23:0] exp_rgb;
      exp_rgb = tbl[i].exp_in ? mem[tbl[i].exp_addr] : 24'h0;
      set_tank(tbl[i].tx, tbl[i].ty, tbl[i].dir);
      cycle(1'b1, 1'b0, 0, 0);
      cycle(1'b0, 1'b1, tbl[i].x, tbl[i].y);
      chk("tbl_addr", 32'(ram_bus.read_address), tbl[i].exp_addr);
      chk("tbl_dir", 32'(ram_bus.dir_sel), tbl[i].dir);
      idle(2);
      chk("tbl_valid", 32'(pixel_out_valid), 32'd1);
      chk("tbl_rgb", 32'(pixel_rgb), 32'(exp_rgb));
      chk("tbl_draw", 32'(pixel_draw), 32'(tbl[i].exp_in && (exp_rgb != KEY_RGB)));
    end
    idle(2);

    // Shadow registers ignore mid-frame changes; coincident pixel uses old position.
    set_tank(100, 200, 2);
    cycle(1'b1, 1'b0, 0, 0);
    tank_x_in = 10'd300;
    cycle(1'b0, 1'b1, 105, 200);
    chk("shadow_hold", 32'(ram_bus.read_address), 32'd5);
    cycle(1'b1, 1'b1, 105, 200);
    chk("fs_old_pos", 32'(ram_bus.read_address), 32'd5);
    cycle(1'b0, 1'b1, 305, 201);
    chk("fs_new_pos", 32'(ram_bus.read_address), 32'd37);
    idle(3);

    // Full box with exactly 100 opaque words.
    for (int i = 0; i < 1024; i++) mem[i] = (i < 1000 && i % 10 == 3) ? {4'h2, 10'(i), 10'(i)} : KEY_RGB;
    set_tank(100, 200, 0);
    cycle(1'b1, 1'b0, 0, 0);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) cycle(1'b0, 1'b1, 100 + x, 200 + y);
    idle(3);
    cycle(1'b1, 1'b0, 0, 0);
    chk("opaque_100", 32'(opaque_count), 32'd100);

    // Counter saturation: three passes over a fully opaque box.
    for (int i = 0; i < 1024; i++) mem[i] = {4'h3, 10'(i), 10'(i)};
    cycle(1'b1, 1'b0, 0, 0);
    for (int p = 0; p < 3; p++)
      for (int a = 0; a < 1024; a++) cycle(1'b0, 1'b1, 100 + a % 32, 200 + a / 32);
    idle(3);
    cycle(1'b1, 1'b0, 0, 0);
    chk("opaque_sat", 32'(opaque_count), 32'd2047);
    cycle(1'b1, 1'b0, 0, 0);
    chk("opaque_empty", 32'(opaque_count), 32'd0);
    idle(2);

    // Random scans with random tank moves and frame starts.
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 3) == 0) ? KEY_RGB : 24'($urandom);
    for (int n = 0; n < 3000; n++) begin
      int x, y;
      if ($urandom_range(0, 15) == 0)
        set_tank($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3));
      x = m_sx + $urandom_range(0, 40) - 4;
      y = m_sy + $urandom_range(0, 40) - 4;
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, x, y);
    end
    idle(3);

    // Reset mid-stream discards in-flight pixels and clears the counter.
    for (int i = 0; i < 1024; i++) mem[i] = {4'h4, 10'(i), 10'(i)};
    set_tank(50, 60, 1);
    cycle(1'b1, 1'b0, 0, 0);
    for (int a = 0; a < 20; a++) cycle(1'b0, 1'b1, 50 + a, 60);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 0, 0);
      chk("rst_no_valid", 32'(pixel_out_valid), 32'd0);
      chk("rst_opaque", 32'(opaque_count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
